hw_seq_ctrl: RTL and testbench
==============================

Name: hw_seq_ctrl

Overview:
- Parametrised successor of the single-instruction-width hardwired controller.
- Generates its own one-hot beat sequence with a variable beat count per opcode, replacing externally supplied W1..W3 timing.
- Supports N-register console access, a single-step mode and a vectored interrupt entry sequence.
- Sits between the IR/flag registers and the datapath. Emits one registered control word per cycle.

Parameters:
- OPW, 4: opcode width (IR high field).
- MAX_BEATS, 4: maximum beats per instruction, including the fetch beat. Must be ≥ 3.
- NREG, 4: number of console-addressable registers. Must be a power of 2, ≥ 2.
- RSW, 2: register index width, equal to clog2(NREG).
- CW, 24: control-word width. Bit map is defined in the package.

Ports:
- T3  in  1  clock, rising edge.
- CLR  in  1  reset, synchronous, active-high.
- SW  in  3  mode select {SWC,SWB,SWA}.
- GO  in  1  start/step strobe, one cycle wide.
- STEP_MODE  in  1  when 1, stop after every instruction.
- IR_OP  in  OPW  current opcode. Valid from the beat after the fetch beat.
- C  in  1  carry flag.
- Z  in  1  zero flag.
- IRQ  in  1  interrupt request, level.
- IE  in  1  interrupt enable, level.
- CTRL  out  CW  registered control word.
- BEAT  out  MAX_BEATS  one-hot beat indicator. All-zero when no beat is active.
- REG_IDX  out  RSW  console register index.
- ST0  out  1  phase flag: 0 = initial, 1 = running/continuation.
- STOP  out  1  clock-stop request to the timing unit.
- IACK  out  1  interrupt acknowledge pulse.

Behaviour:
- Reset (CLR=1 at a T3 edge) has priority over everything, including mid-instruction and mid-interrupt. Values after that edge:
  - state = IDLE; CTRL = 0; BEAT = 0; ST0 = 0; REG_IDX = 0; IACK = 0; STOP = 1.
- States: IDLE, CONS, LDPC, RUN, INT, HALT.
- All outputs are registered. CTRL and BEAT presented in cycle n describe the beat executing in cycle n. They are computed from the next state at edge n.
- SW is registered every cycle as SW_q. A change of SW in IDLE or HALT clears ST0 and REG_IDX. A change during RUN takes effect at the next instruction boundary, where RUN exits to IDLE.
- IDLE (STOP=1): GO dispatches on SW. GO is ignored in all states except IDLE and HALT.
  - 100 write-reg: CONS for one beat with DRW|SBUS|SELCTL. Then REG_IDX increments, wrapping from NREG-1 to 0.
  - 011 read-reg: CONS for one beat with SELCTL, then REG_IDX increments.
  - 010 read-mem: the first GO after a mode change gives LAR|SBUS|SHORT and sets ST0. Later GOs give MBUS|ARINC|SHORT.
  - 001 write-mem: first GO gives LAR|SBUS|SHORT and sets ST0. Later GOs give MEMW|SBUS|ARINC|SHORT.
  - 000 with ST0=0: LDPC for one beat (LPC|SBUS), sets ST0, then RUN at beat 1.
  - 000 with ST0=1: RUN at beat 1.
  - 101, 110, 111: GO is ignored.
  - CONS always returns to IDLE after one cycle.
- RUN:
  - Beat 1 is the fetch beat: LIR|PCINC.
  - Beats 2..NB(IR_OP) are the execute beats. CTRL comes from the decode table.
  - NB is taken from the package. Its range is 2..MAX_BEATS, enforced by an elaboration check.
  - C and Z are sampled in beat 2. JC/JZ assert PCADD only if the sampled flag is 1.
- Instruction boundary (the last beat of an instruction). Priority order:
  1. STP opcode → HALT.
  2. IRQ & IE → INT.
  3. STEP_MODE → IDLE.
  4. SW_q ≠ 000 → IDLE.
  5. Otherwise → RUN beat 1, with no bubble cycle.
- INT (two beats):
  - Beat 1: the INT_SAVE bit group (PC pushed to the save register).
  - Beat 2: LPC with VEC_SEL, and IACK = 1 for exactly this cycle.
  - Then RUN beat 1. IRQ is not re-sampled until the next boundary.
- HALT: STOP = 1. GO resumes RUN beat 1 with ST0 kept at 1.
- STOP is 0 only in LDPC, RUN and INT.

Decomposition:
- Package hw_ctrl_pkg holds:
  - SW mode encodings;
  - opcode constants: ADD, SUB, AND, INC, LD, ST, JC, JZ, JMP, OUTA, NOT, MOV, OR, STP, CMP;
  - CTRL bit indices and S/M field positions;
  - the state enum;
  - the nb_of(op) beat-count function (LD/ST = 3, others = 2);
  - the INT_SAVE and VEC_SEL bit groups.
- Sub-module hw_ctrl_decode: purely combinational. Maps (state, beat index, opcode, sampled C/Z, SW_q, ST0, REG_IDX) to a CTRL word. The top level holds only the state register, beat counter, flag samples and output flops.

Test Plan:
- Write-reg wrap: CLR, SW=100, 5 GO pulses → REG_IDX goes 1, 2, 3, 0, 1; each GO gives a 1-cycle CTRL with DRW=1 and SELCTL=1.
- Run sequence: SW=000, GO, program ADD, LD, STP → LDPC for 1 cycle, then BEAT = 0001, 0010 (ADD), then 0001, 0010, 0100 (LD, with MBUS|DRW in beat 3), then HALT with STOP=1 and no idle cycle between instructions.
- JZ flags: JZ with Z=1 in beat 2 → PCADD=1; Z=1 only in beat 1 → PCADD=0.
- Interrupt entry: IRQ=1, IE=1 during ADD beat 2 → next cycle INT beat 1, then INT beat 2 with IACK=1 and LPC=1 for exactly 1 cycle, then RUN beat 1. Same stimulus with IE=0 → no INT.
- Step mode: STEP_MODE=1 → after every instruction IDLE with STOP=1; GO restarts at beat 1 with ST0=1.
- Reset mid-op: CLR=1 during LD beat 2 → next edge CTRL=0, BEAT=0, ST0=0, STOP=1. GO with ST0=0 → LDPC again.

Source files
------------

// File: rtl/hw_ctrl_pkg.sv
// Shared definitions for the hardwired sequencer: console modes, opcodes,
// control-word bit map, FSM states and the per-opcode beat count.
package hw_ctrl_pkg;

    localparam int CTRL_W = 24;

    // Console mode encodings {SWC,SWB,SWA}
    localparam logic [2:0] SW_RUN  = 3'b000;
    localparam logic [2:0] SW_WMEM = 3'b001;
    localparam logic [2:0] SW_RMEM = 3'b010;
    localparam logic [2:0] SW_RREG = 3'b011;
    localparam logic [2:0] SW_WREG = 3'b100;

    // Opcodes (IR high field); 0 decodes as a two-beat no-op
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_AND  = 3;
    localparam int unsigned OP_INC  = 4;
    localparam int unsigned OP_LD   = 5;
    localparam int unsigned OP_ST   = 6;
    localparam int unsigned OP_JC   = 7;
    localparam int unsigned OP_JZ   = 8;
    localparam int unsigned OP_JMP  = 9;
    localparam int unsigned OP_OUTA = 10;
    localparam int unsigned OP_NOT  = 11;
    localparam int unsigned OP_MOV  = 12;
    localparam int unsigned OP_OR   = 13;
    localparam int unsigned OP_STP  = 14;
    localparam int unsigned OP_CMP  = 15;

    // Control-word bit indices
    localparam int B_LPC    = 0;
    localparam int B_LIR    = 1;
    localparam int B_PCINC  = 2;
    localparam int B_PCADD  = 3;
    localparam int B_DRW    = 4;
    localparam int B_SBUS   = 5;
    localparam int B_MBUS   = 6;
    localparam int B_LAR    = 7;
    localparam int B_ARINC  = 8;
    localparam int B_MEMW   = 9;
    localparam int B_SHORT  = 10;
    localparam int B_SELCTL = 11;
    localparam int B_LDC    = 12;
    localparam int B_LDZ    = 13;
    localparam int B_CIN    = 14;
    localparam int B_M      = 15;
    localparam int S_LSB    = 16;   // ALU function select S[3:0] at [19:16]
    localparam int S_W      = 4;
    localparam int B_ABUS   = 20;
    localparam int B_SAVEPC = 21;
    localparam int B_SPDEC  = 22;
    localparam int B_VECSEL = 23;

    localparam logic [CTRL_W-1:0] C_LPC    = CTRL_W'(1) << B_LPC;
    localparam logic [CTRL_W-1:0] C_LIR    = CTRL_W'(1) << B_LIR;
    localparam logic [CTRL_W-1:0] C_PCINC  = CTRL_W'(1) << B_PCINC;
    localparam logic [CTRL_W-1:0] C_PCADD  = CTRL_W'(1) << B_PCADD;
    localparam logic [CTRL_W-1:0] C_DRW    = CTRL_W'(1) << B_DRW;
    localparam logic [CTRL_W-1:0] C_SBUS   = CTRL_W'(1) << B_SBUS;
    localparam logic [CTRL_W-1:0] C_MBUS   = CTRL_W'(1) << B_MBUS;
    localparam logic [CTRL_W-1:0] C_LAR    = CTRL_W'(1) << B_LAR;
    localparam logic [CTRL_W-1:0] C_ARINC  = CTRL_W'(1) << B_ARINC;
    localparam logic [CTRL_W-1:0] C_MEMW   = CTRL_W'(1) << B_MEMW;
    localparam logic [CTRL_W-1:0] C_SHORT  = CTRL_W'(1) << B_SHORT;
    localparam logic [CTRL_W-1:0] C_SELCTL = CTRL_W'(1) << B_SELCTL;
    localparam logic [CTRL_W-1:0] C_LDC    = CTRL_W'(1) << B_LDC;
    localparam logic [CTRL_W-1:0] C_LDZ    = CTRL_W'(1) << B_LDZ;
    localparam logic [CTRL_W-1:0] C_CIN    = CTRL_W'(1) << B_CIN;

    // Interrupt entry groups: push PC, then load PC from the vector
    localparam logic [CTRL_W-1:0] INT_SAVE = (CTRL_W'(1) << B_SAVEPC) | (CTRL_W'(1) << B_SPDEC);
    localparam logic [CTRL_W-1:0] VEC_SEL  = C_LPC | (CTRL_W'(1) << B_VECSEL);

    typedef enum logic [2:0] {
        S_IDLE, S_CONS, S_LDPC, S_RUN, S_INT, S_HALT
    } state_t;

    // ALU operation driven onto ABUS with the given mode and function select
    function automatic logic [CTRL_W-1:0] alu_op(input logic m, input logic [S_W-1:0] s);
        logic [CTRL_W-1:0] w;
        w = '0;
        w[B_M]              = m;
        w[S_LSB +: S_W]     = s;
        w[B_ABUS]           = 1'b1;
        return w;
    endfunction

    // Beats per instruction including fetch
    function automatic int unsigned nb_of(input int unsigned op);
        case (op)
            OP_LD, OP_ST: return 3;
            default:      return 2;
        endcase
    endfunction

endpackage

// File: rtl/hw_ctrl_decode.sv
// Combinational control-word decode for the beat about to execute.
module hw_ctrl_decode
    import hw_ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int BW  = 3
) (
    input  state_t            state,
    input  logic [BW-1:0]     beat,
    input  logic [OPW-1:0]    op,
    input  logic              c_s,
    input  logic              z_s,
    input  logic [2:0]        sw_q,
    input  logic              st0,
    output logic [CTRL_W-1:0] ctrl
);

    logic [CTRL_W-1:0] e2, e3;

    // Execute-beat words per opcode (beat 2 and beat 3)
    always_comb begin
        e2 = '0;
        e3 = '0;
        case (op)
            OPW'(OP_ADD):  e2 = alu_op(1'b0, 4'b1001) | C_CIN | C_DRW | C_LDC | C_LDZ;
            OPW'(OP_SUB):  e2 = alu_op(1'b0, 4'b0110) | C_DRW | C_LDC | C_LDZ;
            OPW'(OP_AND):  e2 = alu_op(1'b1, 4'b1011) | C_DRW | C_LDZ;
            OPW'(OP_INC):  e2 = alu_op(1'b0, 4'b0000) | C_DRW | C_LDC | C_LDZ;
            OPW'(OP_LD): begin
                e2 = alu_op(1'b1, 4'b1010) | C_LAR;
                e3 = C_MBUS | C_DRW;
            end
            OPW'(OP_ST): begin
                e2 = alu_op(1'b1, 4'b1111) | C_LAR;
                e3 = alu_op(1'b1, 4'b1010) | C_MEMW;
            end
            OPW'(OP_JC):   e2 = c_s ? C_PCADD : '0;
            OPW'(OP_JZ):   e2 = z_s ? C_PCADD : '0;
            OPW'(OP_JMP):  e2 = alu_op(1'b1, 4'b1111) | C_LPC;
            OPW'(OP_OUTA): e2 = alu_op(1'b1, 4'b1010);
            OPW'(OP_NOT):  e2 = alu_op(1'b1, 4'b0000) | C_DRW | C_LDZ;
            OPW'(OP_MOV):  e2 = alu_op(1'b1, 4'b1010) | C_DRW;
            OPW'(OP_OR):   e2 = alu_op(1'b1, 4'b1110) | C_DRW | C_LDZ;
            OPW'(OP_CMP):  e2 = alu_op(1'b0, 4'b0110) | C_LDC | C_LDZ;
            OPW'(OP_STP):  e2 = '0;
            default:       e2 = '0;
        endcase
    end

    // Select the word for the state/beat being entered
    always_comb begin
        ctrl = '0;
        case (state)
            S_CONS: begin
                case (sw_q)
                    SW_WREG: ctrl = C_DRW | C_SBUS | C_SELCTL;
                    SW_RREG: ctrl = C_SELCTL;
                    SW_RMEM: ctrl = st0 ? (C_MBUS | C_ARINC | C_SHORT)
                                        : (C_LAR | C_SBUS | C_SHORT);
                    SW_WMEM: ctrl = st0 ? (C_MEMW | C_SBUS | C_ARINC | C_SHORT)
                                        : (C_LAR | C_SBUS | C_SHORT);
                    default: ctrl = '0;
                endcase
            end
            S_LDPC: ctrl = C_LPC | C_SBUS;
            S_INT:  ctrl = (beat == BW'(1)) ? INT_SAVE : VEC_SEL;
            S_RUN: begin
                if (beat == BW'(1))      ctrl = C_LIR | C_PCINC;
                else if (beat == BW'(2)) ctrl = e2;
                else if (beat == BW'(3)) ctrl = e3;
                else                     ctrl = '0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/hw_seq_ctrl.sv
// Hardwired sequencer: owns state, beat counter, flag sample and the
// registered outputs. Every output describes the beat executing in the
// cycle it is presented, so all of them are computed from the next state.
module hw_seq_ctrl
    import hw_ctrl_pkg::*;
#(
    parameter int OPW       = 4,
    parameter int MAX_BEATS = 4,
    parameter int NREG      = 4,
    parameter int RSW       = 2,
    parameter int CW        = 24
) (
    input  logic                 T3,
    input  logic                 CLR,
    input  logic [2:0]           SW,
    input  logic                 GO,
    input  logic                 STEP_MODE,
    input  logic [OPW-1:0]       IR_OP,
    input  logic                 C,
    input  logic                 Z,
    input  logic                 IRQ,
    input  logic                 IE,
    output logic [CW-1:0]        CTRL,
    output logic [MAX_BEATS-1:0] BEAT,
    output logic [RSW-1:0]       REG_IDX,
    output logic                 ST0,
    output logic                 STOP,
    output logic                 IACK
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    if (MAX_BEATS < 3) begin : g_err_beats
        $error("MAX_BEATS must be at least 3");
    end
    if (NREG < 2 || (NREG & (NREG - 1)) != 0 || RSW != $clog2(NREG)) begin : g_err_nreg
        $error("NREG must be a power of two >= 2 with RSW = clog2(NREG)");
    end
    if (CW != CTRL_W || OPW < 4) begin : g_err_width
        $error("CW must match the package control-word map and OPW must be >= 4");
    end
    for (genvar g = 0; g < 2**OPW; g++) begin : g_nb
        if (nb_of(g) < 2 || nb_of(g) > MAX_BEATS) begin : g_err
            $error("beat count out of range for an opcode");
        end
    end

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d, nb_cur;
    logic                  st0_q, st0_d;
    logic [RSW-1:0]        reg_q, reg_d;
    logic [2:0]            sw_q;
    logic                  sw_chg, open_b2, c_use, z_use;
    logic [1:0]            cz_q;
    logic [CTRL_W-1:0]     ctrl_d;
    logic [MAX_BEATS-1:0]  beat_oh_d;
    logic [CW-1:0]         ctrl_q;
    logic [MAX_BEATS-1:0]  beat_oh_q;
    logic                  stop_q, iack_q;

    assign nb_cur = BW'(nb_of(32'(IR_OP)));
    assign sw_chg = (SW != sw_q);

    // Flags are captured at the edge that opens beat 2; that beat's word
    // uses the live value, any later beat uses the captured one.
    assign open_b2 = (state_d == S_RUN) && (beat_d == BW'(2));
    assign c_use   = open_b2 ? C : cz_q[1];
    assign z_use   = open_b2 ? Z : cz_q[0];

    // Next-state, beat, phase-flag and register-index logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        st0_d   = st0_q;
        reg_d   = reg_q;
        case (state_q)
            S_IDLE: begin
                if (sw_chg) begin
                    st0_d = 1'b0;
                    reg_d = '0;
                end else if (GO) begin
                    case (sw_q)
                        SW_WREG, SW_RREG: state_d = S_CONS;
                        SW_RMEM, SW_WMEM: begin
                            state_d = S_CONS;
                            st0_d   = 1'b1;
                        end
                        SW_RUN: begin
                            if (st0_q) begin
                                state_d = S_RUN;
                                beat_d  = BW'(1);
                            end else begin
                                state_d = S_LDPC;
                                st0_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CONS: begin
                state_d = S_IDLE;
                if (sw_chg) begin
                    st0_d = 1'b0;
                    reg_d = '0;
                end else if (sw_q == SW_WREG || sw_q == SW_RREG) begin
                    reg_d = reg_q + RSW'(1);
                end
            end
            S_LDPC: begin
                state_d = S_RUN;
                beat_d  = BW'(1);
            end
            S_RUN: begin
                if (beat_q >= nb_cur) begin
                    if (IR_OP == OPW'(OP_STP)) begin
                        state_d = S_HALT;
                        beat_d  = '0;
                    end else if (IRQ && IE) begin
                        state_d = S_INT;
                        beat_d  = BW'(1);
                    end else if (STEP_MODE) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end else if (sw_q != SW_RUN) begin
                        // a mode change made while running lands here
                        state_d = S_IDLE;
                        beat_d  = '0;
                        st0_d   = 1'b0;
                        reg_d   = '0;
                    end else begin
                        beat_d  = BW'(1);
                    end
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_INT: begin
                if (beat_q == BW'(1)) begin
                    beat_d = BW'(2);
                end else begin
                    state_d = S_RUN;
                    beat_d  = BW'(1);
                end
            end
            S_HALT: begin
                if (sw_chg || (GO && sw_q != SW_RUN)) begin
                    state_d = S_IDLE;
                    st0_d   = 1'b0;
                    reg_d   = '0;
                end else if (GO) begin
                    state_d = S_RUN;
                    beat_d  = BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // One-hot beat indicator for the beat being entered
    always_comb begin
        beat_oh_d = '0;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (beat_d == BW'(i + 1)) beat_oh_d[i] = 1'b1;
        end
    end

    hw_ctrl_decode #(.OPW(OPW), .BW(BW)) u_dec (
        .state (state_d),
        .beat  (beat_d),
        .op    (IR_OP),
        .c_s   (c_use),
        .z_s   (z_use),
        .sw_q  (sw_q),
        .st0   (st0_q),
        .ctrl  (ctrl_d)
    );

    // Mode switches are sampled every cycle, reset included, so leaving
    // reset never looks like a mode change
    always_ff @(posedge T3) begin
        sw_q <= SW;
    end

    // State, flag sample and registered outputs
    always_ff @(posedge T3) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            st0_q     <= 1'b0;
            reg_q     <= '0;
            cz_q      <= '0;
            ctrl_q    <= '0;
            beat_oh_q <= '0;
            stop_q    <= 1'b1;
            iack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            st0_q     <= st0_d;
            reg_q     <= reg_d;
            if (open_b2) cz_q <= {C, Z};
            ctrl_q    <= CW'(ctrl_d);
            beat_oh_q <= beat_oh_d;
            stop_q    <= !(state_d inside {S_LDPC, S_RUN, S_INT});
            iack_q    <= (state_d == S_INT) && (beat_d == BW'(2));
        end
    end

    assign CTRL    = ctrl_q;
    assign BEAT    = beat_oh_q;
    assign REG_IDX = reg_q;
    assign ST0     = st0_q;
    assign STOP    = stop_q;
    assign IACK    = iack_q;

endmodule

// File: tb/tb_hw_seq_ctrl.sv
// Directed bench for hw_seq_ctrl. Inputs change 1 time unit after a rising
// edge and are therefore seen at the next edge; outputs are checked at the
// same point, i.e. they show the beat opened by the edge just taken.
module tb_hw_seq_ctrl;

    // Hand-derived control words (bit map: LPC0 LIR1 PCINC2 PCADD3 DRW4
    // SBUS5 MBUS6 LAR7 ARINC8 MEMW9 SHORT10 SELCTL11 LDC12 LDZ13 CIN14 M15
    // S19:16 ABUS20 SAVEPC21 SPDEC22 VECSEL23)
    localparam logic [31:0] W_WREG  = 32'h000830;
    localparam logic [31:0] W_RREG  = 32'h000800;
    localparam logic [31:0] W_MFST  = 32'h0004A0;
    localparam logic [31:0] W_RMEM  = 32'h000540;
    localparam logic [31:0] W_WMEM  = 32'h000720;
    localparam logic [31:0] W_LDPC  = 32'h000021;
    localparam logic [31:0] W_FETCH = 32'h000006;
    localparam logic [31:0] W_ADD   = 32'h197010;
    localparam logic [31:0] W_LD2   = 32'h1A8080;
    localparam logic [31:0] W_LD3   = 32'h000050;
    localparam logic [31:0] W_PCADD = 32'h000008;
    localparam logic [31:0] W_INT1  = 32'h600000;
    localparam logic [31:0] W_INT2  = 32'h800001;

    localparam logic [3:0] ADD = 4'd1, LD = 4'd5, JZ = 4'd8, STP = 4'd14;

    logic        T3 = 1'b0;
    logic        CLR, GO, STEP_MODE, C, Z, IRQ, IE;
    logic [2:0]  SW;
    logic [3:0]  IR_OP;
    logic [23:0] CTRL;
    logic [3:0]  BEAT;
    logic [1:0]  REG_IDX;
    logic        ST0, STOP, IACK;

    int n_cmp = 0;
    int n_bad = 0;
    int idx_pre  [5] = '{0, 1, 2, 3, 0};
    int idx_post [5] = '{1, 2, 3, 0, 1};

    hw_seq_ctrl dut (
        .T3(T3), .CLR(CLR), .SW(SW), .GO(GO), .STEP_MODE(STEP_MODE),
        .IR_OP(IR_OP), .C(C), .Z(Z), .IRQ(IRQ), .IE(IE),
        .CTRL(CTRL), .BEAT(BEAT), .REG_IDX(REG_IDX), .ST0(ST0),
        .STOP(STOP), .IACK(IACK)
    );

    always #5 T3 = ~T3;

    task automatic tick();
        @(posedge T3);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        CLR = 1'b1; SW = 3'b100; GO = 1'b0; STEP_MODE = 1'b0; IR_OP = '0;
        C = 1'b0; Z = 1'b0; IRQ = 1'b0; IE = 1'b0;
        tick(); tick();
        chk("rst_ctrl", 32'(CTRL), 0);
        chk("rst_beat", 32'(BEAT), 0);
        chk("rst_st0",  32'(ST0), 0);
        chk("rst_idx",  32'(REG_IDX), 0);
        chk("rst_iack", 32'(IACK), 0);
        chk("rst_stop", 32'(STOP), 1);
        CLR = 1'b0;
        tick();

        // write-reg: index wraps after NREG-1
        for (int i = 0; i < 5; i++) begin
            GO = 1'b1; tick(); GO = 1'b0;
            chk("wreg_ctrl", 32'(CTRL), W_WREG);
            chk("wreg_idx_in", 32'(REG_IDX), 32'(idx_pre[i]));
            tick();
            chk("wreg_idx", 32'(REG_IDX), 32'(idx_post[i]));
            chk("wreg_off", 32'(CTRL), 0);
        end

        // read-reg after a mode change restarts at index 0
        SW = 3'b011; tick();
        chk("rreg_clr", 32'(REG_IDX), 0);
        GO = 1'b1; tick(); GO = 1'b0;
        chk("rreg_ctrl", 32'(CTRL), W_RREG);
        tick();
        chk("rreg_idx", 32'(REG_IDX), 1);

        // reserved mode ignores GO
        SW = 3'b101; tick();
        GO = 1'b1; tick(); GO = 1'b0;
        chk("rsv_ctrl", 32'(CTRL), 0);
        chk("rsv_stop", 32'(STOP), 1);

        // read-mem: address load first, then reads
        SW = 3'b010; tick();
        GO = 1'b1; tick(); GO = 1'b0;
        chk("rmem_first", 32'(CTRL), W_MFST);
        chk("rmem_st0", 32'(ST0), 1);
        tick();
        GO = 1'b1; tick(); GO = 1'b0;
        chk("rmem_next", 32'(CTRL), W_RMEM);

        // run ADD, LD, STP
        SW = 3'b000; tick();
        chk("run_st0clr", 32'(ST0), 0);
        IR_OP = ADD;
        GO = 1'b1; tick(); GO = 1'b0;
        chk("ldpc_ctrl", 32'(CTRL), W_LDPC);
        chk("ldpc_beat", 32'(BEAT), 0);
        chk("ldpc_stop", 32'(STOP), 0);
        chk("ldpc_st0", 32'(ST0), 1);
        tick();
        chk("add_b1", 32'(BEAT), 4'b0001);
        chk("add_fetch", 32'(CTRL), W_FETCH);
        tick();
        chk("add_b2", 32'(BEAT), 4'b0010);
        chk("add_ctrl", 32'(CTRL), W_ADD);
        tick();
        chk("ld_b1", 32'(BEAT), 4'b0001);
        chk("ld_b1_stop", 32'(STOP), 0);
        IR_OP = LD; tick();
        chk("ld_b2", 32'(BEAT), 4'b0010);
        chk("ld_ctrl2", 32'(CTRL), W_LD2);
        tick();
        chk("ld_b3", 32'(BEAT), 4'b0100);
        chk("ld_ctrl3", 32'(CTRL), W_LD3);
        tick();
        chk("stp_b1", 32'(BEAT), 4'b0001);
        IR_OP = STP; tick();
        chk("stp_b2", 32'(BEAT), 4'b0010);
        tick();
        chk("halt_stop", 32'(STOP), 1);
        chk("halt_beat", 32'(BEAT), 0);
        chk("halt_st0", 32'(ST0), 1);

        // JZ: flag present when beat 2 opens -> taken
        GO = 1'b1; IR_OP = JZ; Z = 1'b1; tick(); GO = 1'b0;
        chk("resume_b1", 32'(BEAT), 4'b0001);
        chk("resume_stop", 32'(STOP), 0);
        tick();
        chk("jz_taken", 32'(CTRL), W_PCADD);
        // Z high only when beat 1 opens -> not taken
        tick();
        chk("jz2_b1", 32'(BEAT), 4'b0001);
        Z = 1'b0; tick();
        chk("jz_not", 32'(CTRL), 0);

        // interrupt entry at the ADD boundary
        tick();
        IR_OP = ADD; tick();
        chk("irq_add_b2", 32'(CTRL), W_ADD);
        IRQ = 1'b1; IE = 1'b1; tick();
        chk("int1_ctrl", 32'(CTRL), W_INT1);
        chk("int1_beat", 32'(BEAT), 4'b0001);
        chk("int1_iack", 32'(IACK), 0);
        tick();
        chk("int2_ctrl", 32'(CTRL), W_INT2);
        chk("int2_iack", 32'(IACK), 1);
        tick();
        chk("int_ret", 32'(CTRL), W_FETCH);
        chk("int_ret_iack", 32'(IACK), 0);
        // IE low: no entry
        IE = 1'b0; tick(); tick();
        chk("noint_b1", 32'(BEAT), 4'b0001);
        chk("noint_ctrl", 32'(CTRL), W_FETCH);

        // single-step
        IRQ = 1'b0; STEP_MODE = 1'b1; tick(); tick();
        chk("step_stop", 32'(STOP), 1);
        chk("step_beat", 32'(BEAT), 0);
        chk("step_st0", 32'(ST0), 1);
        GO = 1'b1; tick(); GO = 1'b0;
        chk("step_go_b1", 32'(BEAT), 4'b0001);
        chk("step_go_ctrl", 32'(CTRL), W_FETCH);
        tick(); tick();
        chk("step_stop2", 32'(STOP), 1);
        STEP_MODE = 1'b0;

        // reset in the middle of LD
        GO = 1'b1; IR_OP = LD; tick(); GO = 1'b0;
        tick();
        chk("mid_ld_b2", 32'(CTRL), W_LD2);
        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("mrst_ctrl", 32'(CTRL), 0);
        chk("mrst_beat", 32'(BEAT), 0);
        chk("mrst_st0", 32'(ST0), 0);
        chk("mrst_stop", 32'(STOP), 1);
        GO = 1'b1; tick(); GO = 1'b0;
        chk("mrst_ldpc", 32'(CTRL), W_LDPC);
        tick();

        // mode change while running exits at the boundary
        SW = 3'b001; tick(); tick(); tick();
        chk("swx_stop", 32'(STOP), 1);
        chk("swx_beat", 32'(BEAT), 0);
        GO = 1'b1; tick(); GO = 1'b0;
        chk("wmem_first", 32'(CTRL), W_MFST);
        tick();
        GO = 1'b1; tick(); GO = 1'b0;
        chk("wmem_next", 32'(CTRL), W_WMEM);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
